fp_sub: RTL and testbench
=========================

FP_SUB -- requirements
Module: fp_sub

Interface
REQ-001 The block SHALL take parameter i1, default 2, integer bits of operand a.
REQ-002 The block SHALL take parameter f1, default 14, fraction bits of operand a.
REQ-003 The block SHALL take parameter i2, default 2, integer bits of operand b.
REQ-004 The block SHALL take parameter f2, default 14, fraction bits of operand b.
REQ-005 The block SHALL take parameter i3, default 2, integer bits of result c.
REQ-006 The block SHALL take parameter f3, default 13, fraction bits of result c.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-008 The block SHALL have these ports: in_valid input 1 operand valid; in_ready output 1 operands accepted this cycle; a input i1+f1 minuend; s1 input 1 a is two's complement (0 = unsigned); b input i2+f2 subtrahend; s2 input 1 b is two's complement.
REQ-009 The block SHALL have these ports: out_valid output 1 result valid; out_ready input 1 consumer accepts; c output i3+f3 result; sign output 1 c is two's complement; overflow output 1 result saturated; underflow output 1 nonzero result truncated to zero.
REQ-010 The block SHALL have these ports: clr_flags input 1 clear sticky state; ovf_sticky output 1; udf_sticky output 1; ovf_count output 8 saturating overflow count.

Function
REQ-011 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output); at most one result per cycle.
REQ-012 Pipeline SHALL be 2 stages: S1 aligns and subtracts; S2 saturates, truncates and flags; latency exactly 2 cycles with out_ready held high.
REQ-013 S1 SHALL zero-extend unsigned operands and sign-extend signed ones, align to IF = max(f1,f2) fraction bits, and form exact a-b in a signed word of max(i1,i2)+2 integer bits (no internal loss).
REQ-014 sign SHALL equal s1|s2 of the transaction, registered alongside its result.
REQ-015 Truncation SHALL drop the IF-f3 LSBs (round toward minus infinity); when f3 >= IF, LSBs are zero-padded.
REQ-016 Signed result above 2^(i3-1)-2^-f3 SHALL give c = 0 followed by all ones; below -2^(i3-1) SHALL give c = 1 followed by all zeros; overflow=1 in both cases.
REQ-017 Unsigned result (sign=0) above 2^i3-2^-f3 SHALL give all-ones c; a negative result SHALL give c = 0; overflow=1 in both cases.
REQ-018 underflow SHALL be 1 only when exact difference is nonzero, overflow=0, and truncated c is zero.
REQ-019 Stall: S2 SHALL hold c/flags stable while out_valid&!out_ready; S1 SHALL advance into S2 only when S2 is empty or draining.
REQ-020 in_ready SHALL be !(S1 full & S2 full & !out_ready); pipeline SHALL accept a new input in the same cycle the output drains.
REQ-021 ovf_sticky/udf_sticky SHALL set on output transfer of a flagged result; ovf_count SHALL increment on each such overflow and hold at 255.
REQ-022 clr_flags SHALL clear sticky flags and count; a flagged transfer in the same cycle SHALL win (flag set to 1, count to 1).
REQ-023 Inputs SHALL be ignored when in_valid=0; out_valid SHALL fall after transfer unless a following result is ready.

Reset
REQ-024 When rst is high at a clk edge, S1/S2 valid, out_valid, ovf_sticky, udf_sticky and ovf_count SHALL be 0; c, sign, overflow and underflow SHALL be 0.
REQ-025 in_ready SHALL be 0 during reset and 1 in the first cycle after reset.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions with no output transfer.

Verification
REQ-027 Unsigned: a=16'h4000, b=16'h2000, s1=s2=0 -> two cycles later c=15'h1000, sign=0, overflow=0, underflow=0.
REQ-028 Unsigned negative: a=16'h2000, b=16'h4000, s1=s2=0 -> c=15'h0000, overflow=1, ovf_sticky=1, ovf_count=1.
REQ-029 Signed overflow: a=16'h6000, b=16'hA000, s1=s2=1 (1.5-(-1.5)) -> c=15'h3FFF, sign=1, overflow=1; reversed operands -> c=15'h4000, overflow=1.
REQ-030 Underflow: a=16'h0001, b=16'h0000, unsigned -> c=15'h0000, underflow=1, udf_sticky=1; then clr_flags -> sticky flags 0, ovf_count 0.
REQ-031 Backpressure: 3 back-to-back inputs, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, c stable; out_ready=1 -> results drain in order, none lost or duplicated.
REQ-032 rst asserted with both stages full -> next cycle out_valid=0, ovf_count=0, in_ready=1, and no stale result appears.

Source files
------------

// File: rtl/fp_sub.sv
// Two-stage fixed-point subtractor c = a - b with mixed signedness, saturation,
// truncation toward minus infinity, ready/valid handshake and sticky flags.
module fp_sub #(
    parameter int i1 = 2,
    parameter int f1 = 14,
    parameter int i2 = 2,
    parameter int f2 = 14,
    parameter int i3 = 2,
    parameter int f3 = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [i1+f1-1:0] a,
    input  logic             s1,
    input  logic [i2+f2-1:0] b,
    input  logic             s2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [i3+f3-1:0] c,
    output logic             sign,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_flags,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    output logic [7:0]       ovf_count
);
    localparam int WC  = i3 + f3;
    localparam int IF  = (f1 > f2) ? f1 : f2;
    localparam int II  = ((i1 > i2) ? i1 : i2) + 2;
    localparam int DW  = II + IF;
    localparam int FF  = (f3 > IF) ? f3 : IF;
    localparam int TW  = II + ((i3 > II) ? i3 : II) + FF + 2;
    localparam int SHL = (f3 >= IF) ? f3 - IF : 0;
    localparam int SHR = (f3 >= IF) ? 0 : IF - f3;
    localparam int SHA = IF - f1;
    localparam int SHB = IF - f2;

    localparam logic signed [TW-1:0] ONE  = TW'(1);
    localparam logic signed [TW-1:0] SMAX = (ONE <<< (WC - 1)) - ONE;
    localparam logic signed [TW-1:0] SMIN = -(ONE <<< (WC - 1));
    localparam logic signed [TW-1:0] UMAX = (ONE <<< WC) - ONE;

    logic                 s1_v_q, s1_v_d;
    logic signed [DW-1:0] diff_q, diff_d;
    logic                 sgn1_q, sgn1_d;
    logic                 s2_v_q, s2_v_d;
    logic [WC-1:0]        c_q, c_d;
    logic                 sign_q, sign_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                 ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
    logic [7:0]           ovf_count_q, ovf_count_d;

    logic signed [DW-1:0] a_al, b_al;
    logic signed [TW-1:0] wide, t;
    logic [WC-1:0]        c_n;
    logic                 ovf_n, udf_n;
    logic                 load_s2, s1_move, accept, out_xfer;
    logic [7:0]           cnt_base;

    // Stage 1: extend each operand by its own signedness, align to IF fraction bits.
    always_comb begin
        if (s1) a_al = DW'($signed(a));
        else    a_al = DW'(a);
        if (s2) b_al = DW'($signed(b));
        else    b_al = DW'(b);
        a_al = a_al <<< SHA;
        b_al = b_al <<< SHB;
    end

    // Stage 2: rescale to f3 fraction bits (arithmetic shift floors), then clamp.
    always_comb begin
        wide  = TW'(diff_q);
        t     = (wide <<< SHL) >>> SHR;
        c_n   = t[WC-1:0];
        ovf_n = 1'b0;
        if (sgn1_q) begin
            if (t > SMAX) begin
                c_n   = {1'b0, {(WC-1){1'b1}}};
                ovf_n = 1'b1;
            end else if (t < SMIN) begin
                c_n   = {1'b1, {(WC-1){1'b0}}};
                ovf_n = 1'b1;
            end
        end else begin
            if (t < 0) begin
                c_n   = '0;
                ovf_n = 1'b1;
            end else if (t > UMAX) begin
                c_n   = '1;
                ovf_n = 1'b1;
            end
        end
        udf_n = !ovf_n && (diff_q != '0) && (c_n == '0);
    end

    always_comb begin
        load_s2  = !s2_v_q || out_ready;
        s1_move  = s1_v_q && load_s2;
        in_ready = !rst && !(s1_v_q && s2_v_q && !out_ready);
        accept   = in_valid && in_ready;
        out_xfer = s2_v_q && out_ready;

        s1_v_d = accept || (s1_v_q && !s1_move);
        diff_d = accept ? (a_al - b_al) : diff_q;
        sgn1_d = accept ? (s1 | s2) : sgn1_q;

        s2_v_d = load_s2 ? s1_v_q : s2_v_q;
        c_d    = s1_move ? c_n    : c_q;
        sign_d = s1_move ? sgn1_q : sign_q;
        ovf_d  = s1_move ? ovf_n  : ovf_q;
        udf_d  = s1_move ? udf_n  : udf_q;

        // A flagged transfer in the same cycle as clr_flags restarts from one.
        ovf_sticky_d = clr_flags ? 1'b0 : ovf_sticky_q;
        udf_sticky_d = clr_flags ? 1'b0 : udf_sticky_q;
        cnt_base     = clr_flags ? 8'd0 : ovf_count_q;
        ovf_count_d  = cnt_base;
        if (out_xfer && ovf_q) begin
            ovf_sticky_d = 1'b1;
            if (cnt_base != 8'hFF) ovf_count_d = cnt_base + 8'd1;
        end
        if (out_xfer && udf_q) udf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            diff_q       <= '0;
            sgn1_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            c_q          <= '0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
            ovf_count_q  <= 8'd0;
        end else begin
            s1_v_q       <= s1_v_d;
            diff_q       <= diff_d;
            sgn1_q       <= sgn1_d;
            s2_v_q       <= s2_v_d;
            c_q          <= c_d;
            sign_q       <= sign_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign c          = c_q;
    assign sign       = sign_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign udf_sticky = udf_sticky_q;
    assign ovf_count  = ovf_count_q;
endmodule

// File: tb/tb_fp_sub.sv
// Directed bench for fp_sub at default parameters (Q2.14 - Q2.14 -> Q2.13).
module tb_fp_sub;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, s1, s2, out_valid, out_ready;
    logic [15:0] a, b;
    logic [14:0] c;
    logic        sign, overflow, underflow, clr_flags, ovf_sticky, udf_sticky;
    logic [7:0]  ovf_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    fp_sub dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .s1(s1), .b(b), .s2(s2), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .sign(sign), .overflow(overflow), .underflow(underflow),
        .clr_flags(clr_flags), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky),
        .ovf_count(ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction with out_ready high; checks latency and result fields.
    // Returns at the negedge right after the output transfer edge.
    task automatic run1(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts1, input logic ts2, input logic [14:0] ec,
                        input logic es, input logic eo, input logic eu, input logic clr_en);
        @(negedge clk);
        a = ta; b = tb_; s1 = ts1; s2 = ts2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_c"},     32'(c),         32'(ec));
        chk({tag, "_sign"},  32'(sign),      32'(es));
        chk({tag, "_ovf"},   32'(overflow),  32'(eo));
        chk({tag, "_udf"},   32'(underflow), 32'(eu));
        clr_flags = clr_en;
        @(negedge clk);
        clr_flags = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
        a = '0; b = '0; s1 = 1'b0; s2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c",         32'(c),         32'd0);
        chk("rst_count",     32'(ovf_count), 32'd0);
        chk("rst_sticky",    32'({ovf_sticky, udf_sticky}), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 1.0 - 0.5 = 0.5
        run1("uns_basic", 16'h4000, 16'h2000, 0, 0, 15'h1000, 0, 0, 0, 0);
        chk("uns_basic_sticky", 32'({ovf_sticky, udf_sticky}), 32'd0);
        // 0.5 - 1.0 unsigned -> clamp to 0
        run1("uns_neg", 16'h2000, 16'h4000, 0, 0, 15'h0000, 0, 1, 0, 0);
        chk("uns_neg_osticky", 32'(ovf_sticky), 32'd1);
        chk("uns_neg_count",   32'(ovf_count),  32'd1);
        // 1.5 - (-1.5) = 3.0 -> signed max; reversed -> signed min
        run1("sgn_pos_sat", 16'h6000, 16'hA000, 1, 1, 15'h3FFF, 1, 1, 0, 0);
        run1("sgn_neg_sat", 16'hA000, 16'h6000, 1, 1, 15'h4000, 1, 1, 0, 0);
        chk("sgn_count", 32'(ovf_count), 32'd3);
        // Largest unsigned operand just fits: 0xFFFF>>1 = 0x7FFF
        run1("uns_max", 16'hFFFF, 16'h0000, 0, 0, 15'h7FFF, 0, 0, 0, 0);
        // -2^-14 floors to -2^-13: nonzero, so no underflow
        run1("sgn_neg_lsb", 16'h0000, 16'h0001, 1, 1, 15'h7FFF, 1, 0, 0, 0);
        // -1.0 (signed) - 1.0 (unsigned) = -2.0, exactly the signed minimum
        run1("mixed_min", 16'hC000, 16'h4000, 1, 0, 15'h4000, 1, 0, 0, 0);
        chk("mixed_count", 32'(ovf_count), 32'd3);
        // Overflowing transfer coincides with clr_flags: count restarts at 1
        run1("clr_collide", 16'h2000, 16'h4000, 0, 0, 15'h0000, 0, 1, 0, 1);
        chk("clr_collide_count",  32'(ovf_count),  32'd1);
        chk("clr_collide_sticky", 32'(ovf_sticky), 32'd1);
        // 2^-14 truncates to zero
        run1("udf", 16'h0001, 16'h0000, 0, 0, 15'h0000, 0, 0, 1, 0);
        chk("udf_sticky", 32'(udf_sticky), 32'd1);
        @(negedge clk); clr_flags = 1'b1;
        @(negedge clk); clr_flags = 1'b0;
        chk("clr_sticky", 32'({ovf_sticky, udf_sticky}), 32'd0);
        chk("clr_count",  32'(ovf_count), 32'd0);

        // Backpressure: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        s1 = 1'b0; s2 = 1'b0;
        @(negedge clk); a = 16'h4000; b = 16'h2000; in_valid = 1'b1;
        @(negedge clk); a = 16'h6000; b = 16'h0000;
        @(negedge clk); a = 16'h0800; b = 16'h0000;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_c",     32'(c),         32'h1000);
            chk("bp_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(in_ready), 32'd1);
        @(negedge clk); in_valid = 1'b0;
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_out2_c",     32'(c),         32'h3000);
        @(negedge clk);
        chk("bp_out3_valid", 32'(out_valid), 32'd1);
        chk("bp_out3_c",     32'(c),         32'h0400);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Give the counter a nonzero value, then reset with both stages full
        run1("pre_rst_ovf", 16'h2000, 16'h4000, 0, 0, 15'h0000, 0, 1, 0, 0);
        out_ready = 1'b0;
        @(negedge clk); a = 16'h2000; b = 16'h4000; in_valid = 1'b1;
        @(negedge clk); a = 16'h4000; b = 16'h2000;
        @(negedge clk); in_valid = 1'b0;
        chk("full_before_rst", 32'({out_valid, in_ready}), 32'b10);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_count",    32'(ovf_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
